// File: rtl/bridge_commutation_seq.sv
// H-bridge commutation sequencer: inserts an all-off dead-time between gate patterns,
// holds each pattern for a minimum on-time, and latches a fault on kill until cleared.
module bridge_commutation_seq #(
    parameter int DEAD_CYC   = 100,
    parameter int MIN_ON_CYC = 500,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [2:0] req_mode,
    output logic       req_ready,
    input  logic       kill,
    input  logic       clr,
    output logic [3:0] o_top,
    output logic [3:0] o_bot,
    output logic       o_plus,
    output logic       o_minus,
    output logic       o_pause_p,
    output logic       o_pause_n,
    output logic [2:0] cur_mode,
    output logic       busy,
    output logic       fault
);

    localparam int MAX_CYC = (DEAD_CYC > MIN_ON_CYC) ? DEAD_CYC : MIN_ON_CYC;

    generate
        if (DEAD_CYC < 1 || MIN_ON_CYC < 1 ||
            (longint'(MAX_CYC) - 1) >= (longint'(1) << CNT_W)) begin : g_bad_param
            $error("bridge_commutation_seq: DEAD_CYC/MIN_ON_CYC out of range for CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] ON_LOAD   = CNT_W'(MIN_ON_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_DEAD, S_ON, S_KILL} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       pend, pend_n, cur_n, mode_req;
    logic [3:0]       top_n, bot_n, flg, flg_n;
    logic             accept;

    // {top, bot, flags}; flags = {pause_n, pause_p, minus, plus}
    function automatic logic [11:0] pattern(input logic [2:0] m);
        case (m)
            3'd1:    pattern = {4'b0001, 4'b0010, 4'b0001};
            3'd2:    pattern = {4'b0010, 4'b0001, 4'b0010};
            3'd3:    pattern = {4'b0100, 4'b1000, 4'b0100};
            3'd4:    pattern = {4'b1000, 4'b0100, 4'b1000};
            default: pattern = 12'd0;
        endcase
    endfunction

    assign mode_req  = (req_mode > 3'd4) ? 3'd0 : req_mode;
    assign req_ready = ~kill & ((state == S_IDLE) | ((state == S_ON) & (cnt == '0)));
    assign accept    = req_valid & req_ready;
    assign busy      = (state != S_IDLE);
    assign fault     = (state == S_KILL);
    assign o_plus    = flg[0];
    assign o_minus   = flg[1];
    assign o_pause_p = flg[2];
    assign o_pause_n = flg[3];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pend_n  = pend;
        cur_n   = cur_mode;
        top_n   = o_top;
        bot_n   = o_bot;
        flg_n   = flg;
        if (kill) begin
            state_n = S_KILL;
            cnt_n   = '0;
            pend_n  = 3'd0;
            cur_n   = 3'd0;
            top_n   = 4'd0;
            bot_n   = 4'd0;
            flg_n   = 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && mode_req != 3'd0) begin
                        pend_n  = mode_req;
                        cnt_n   = DEAD_LOAD;
                        state_n = S_DEAD;
                    end
                end
                S_DEAD: begin
                    if (cnt == '0) begin
                        if (pend == 3'd0) begin
                            state_n = S_IDLE;
                        end else begin
                            {top_n, bot_n, flg_n} = pattern(pend);
                            cur_n   = pend;
                            cnt_n   = ON_LOAD;
                            state_n = S_ON;
                        end
                    end else begin
                        cnt_n = cnt - CNT_ONE;
                    end
                end
                S_ON: begin
                    // Same-mode request is acknowledged but leaves the pattern and counter alone
                    if (accept && mode_req != cur_mode) begin
                        top_n   = 4'd0;
                        bot_n   = 4'd0;
                        flg_n   = 4'd0;
                        cur_n   = 3'd0;
                        pend_n  = mode_req;
                        cnt_n   = DEAD_LOAD;
                        state_n = S_DEAD;
                    end else if (cnt != '0) begin
                        cnt_n = cnt - CNT_ONE;
                    end
                end
                S_KILL: begin
                    if (clr) state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            pend     <= 3'd0;
            cur_mode <= 3'd0;
            o_top    <= 4'd0;
            o_bot    <= 4'd0;
            flg      <= 4'd0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            pend     <= pend_n;
            cur_mode <= cur_n;
            o_top    <= top_n;
            o_bot    <= bot_n;
            flg      <= flg_n;
        end
    end

endmodule

// File: tb/tb_bridge_commutation_seq.sv
// Scoreboard bench for bridge_commutation_seq with DEAD_CYC=4, MIN_ON_CYC=8: directed
// expectations tagged by cycle, plus per-cycle shoot-through / dead-time / on-time monitors.
module tb_bridge_commutation_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [2:0] req_mode = 3'd0;
    logic       req_ready;
    logic       kill = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] o_top, o_bot;
    logic       o_plus, o_minus, o_pause_p, o_pause_n;
    logic [2:0] cur_mode;
    logic       busy, fault;
    logic [3:0] flg;

    bridge_commutation_seq #(.DEAD_CYC(4), .MIN_ON_CYC(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_mode(req_mode),
        .req_ready(req_ready), .kill(kill), .clr(clr), .o_top(o_top), .o_bot(o_bot),
        .o_plus(o_plus), .o_minus(o_minus), .o_pause_p(o_pause_p), .o_pause_n(o_pause_n),
        .cur_mode(cur_mode), .busy(busy), .fault(fault)
    );

    assign flg = {o_pause_n, o_pause_p, o_minus, o_plus};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [2:0] mode;
        logic       busy;
        logic       fault;
        logic       ready;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   rst_cnt = 0;
    bit   done = 1'b0;

    function automatic logic [11:0] exp_pat(input logic [2:0] m);
        case (m)
            3'd1:    return {4'b0001, 4'b0010, 4'b0001};
            3'd2:    return {4'b0010, 4'b0001, 4'b0010};
            3'd3:    return {4'b0100, 4'b1000, 4'b0100};
            3'd4:    return {4'b1000, 4'b0100, 4'b1000};
            default: return 12'd0;
        endcase
    endfunction

    task automatic expect_at(input int off, input logic [2:0] m, input logic b,
                             input logic f, input logic r, input string name);
        exp_t e;
        e.cyc = cyc + off; e.mode = m; e.busy = b; e.fault = f; e.ready = r; e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: scoreboard pops and safety invariants
    initial begin
        exp_t       e;
        logic [11:0] p;
        logic [3:0] prev_top = 4'd0;
        int         zero_run = 100;
        int         on_run = 0;
        int         seen_rst = 0;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                #1;
                if (rst_cnt > 0 && rst) begin
                    checks++;
                    if (o_top != 0 || o_bot != 0 || flg != 0 || cur_mode != 0 || busy || fault) begin
                        errors++;
                        $display("FAIL async_rst: top=%b bot=%b flg=%b cur=%0d busy=%b fault=%b, expected all 0",
                                 o_top, o_bot, flg, cur_mode, busy, fault);
                    end
                end
                continue;
            end
            if (done) break;
            if (rst_cnt != seen_rst) begin
                seen_rst = rst_cnt; prev_top = 4'd0; zero_run = 100; on_run = 0;
            end
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                p = exp_pat(e.mode);
                checks++;
                if (e.cyc != cyc || o_top !== p[11:8] || o_bot !== p[7:4] || flg !== p[3:0] ||
                    cur_mode !== e.mode || busy !== e.busy || fault !== e.fault || req_ready !== e.ready) begin
                    errors++;
                    $display("FAIL %s cyc=%0d/%0d: got top=%b bot=%b flg=%b cur=%0d busy=%b fault=%b ready=%b, expected top=%b bot=%b flg=%b cur=%0d busy=%b fault=%b ready=%b",
                             e.name, cyc, e.cyc, o_top, o_bot, flg, cur_mode, busy, fault, req_ready,
                             p[11:8], p[7:4], p[3:0], e.mode, e.busy, e.fault, e.ready);
                end
            end
            checks++;
            if ((o_top & o_bot) != 4'd0) begin
                errors++;
                $display("FAIL shoot_through cyc=%0d: top=%b bot=%b, expected no overlap", cyc, o_top, o_bot);
            end
            if (o_top != 0 && prev_top != 0 && o_top != prev_top) begin
                checks++; errors++;
                $display("FAIL direct_change cyc=%0d: top %b -> %b, expected dead-time between", cyc, prev_top, o_top);
            end
            if (o_top != 0 && prev_top == 0) begin
                checks++;
                if (zero_run < 4) begin
                    errors++;
                    $display("FAIL dead_time cyc=%0d: zero cycles=%0d, expected >=4", cyc, zero_run);
                end
            end
            if (o_top == 0 && prev_top != 0 && !fault) begin
                checks++;
                if (on_run < 8) begin
                    errors++;
                    $display("FAIL min_on cyc=%0d: on cycles=%0d, expected >=8", cyc, on_run);
                end
            end
            if (o_top != 0) begin
                on_run   = (prev_top == o_top) ? on_run + 1 : 1;
                zero_run = 0;
            end else begin
                zero_run++;
            end
            prev_top = o_top;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations: pending=%0d, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Stimulus
    initial begin
        tick(2);
        rst = 1'b0;
        tick(1);
        expect_at(0, 3'd0, 1'b0, 1'b0, 1'b1, "reset_state");
        tick(1);

        // IDLE -> PLUS
        req_valid = 1'b1; req_mode = 3'd1;
        expect_at(0, 3'd0, 1'b0, 1'b0, 1'b1, "t1_idle_ready");
        expect_at(1, 3'd0, 1'b1, 1'b0, 1'b0, "t1_dead_first");
        expect_at(4, 3'd0, 1'b1, 1'b0, 1'b0, "t1_dead_last");
        expect_at(5, 3'd1, 1'b1, 1'b0, 1'b0, "t1_plus_on");
        tick(1); req_valid = 1'b0;
        tick(4);

        // Early MINUS request held off by minimum on-time
        tick(2); req_valid = 1'b1; req_mode = 3'd2;
        expect_at(0, 3'd1, 1'b1, 1'b0, 1'b0, "t2_hold_early");
        expect_at(4, 3'd1, 1'b1, 1'b0, 1'b0, "t2_hold_late");
        expect_at(5, 3'd1, 1'b1, 1'b0, 1'b1, "t2_ready_min_on");
        expect_at(6, 3'd0, 1'b1, 1'b0, 1'b0, "t2_dead_first");
        expect_at(9, 3'd0, 1'b1, 1'b0, 1'b0, "t2_dead_last");
        expect_at(10, 3'd2, 1'b1, 1'b0, 1'b0, "t2_minus_on");
        tick(6); req_valid = 1'b0;
        tick(4);

        // OFF request returns to IDLE; invalid mode 6 from IDLE is a no-op
        tick(7); req_valid = 1'b1; req_mode = 3'd0;
        expect_at(0, 3'd2, 1'b1, 1'b0, 1'b1, "t3_ready");
        expect_at(1, 3'd0, 1'b1, 1'b0, 1'b0, "t3_dead_first");
        expect_at(4, 3'd0, 1'b1, 1'b0, 1'b0, "t3_dead_last");
        expect_at(5, 3'd0, 1'b0, 1'b0, 1'b1, "t3_idle");
        tick(1); req_valid = 1'b0;
        tick(4);
        req_valid = 1'b1; req_mode = 3'd6;
        expect_at(1, 3'd0, 1'b0, 1'b0, 1'b1, "t3_mode6_noop");
        expect_at(3, 3'd0, 1'b0, 1'b0, 1'b1, "t3_mode6_idle");
        tick(3); req_valid = 1'b0;
        tick(1);

        // Kill during dead-time with pending BAL_P
        req_valid = 1'b1; req_mode = 3'd3;
        expect_at(1, 3'd0, 1'b1, 1'b0, 1'b0, "t4_dead");
        tick(1); req_valid = 1'b0;
        tick(2); kill = 1'b1;
        expect_at(0, 3'd0, 1'b1, 1'b0, 1'b0, "t4_kill_cycle");
        expect_at(1, 3'd0, 1'b1, 1'b1, 1'b0, "t4_fault");
        expect_at(2, 3'd0, 1'b1, 1'b1, 1'b0, "t4_no_pattern");
        tick(1); clr = 1'b1;
        tick(1); clr = 1'b0;
        expect_at(1, 3'd0, 1'b1, 1'b1, 1'b0, "t4_clr_ignored");
        tick(1); kill = 1'b0; clr = 1'b1;
        expect_at(0, 3'd0, 1'b1, 1'b1, 1'b0, "t4_fault_kill_low");
        expect_at(1, 3'd0, 1'b0, 1'b0, 1'b1, "t4_cleared");
        tick(1); clr = 1'b0;
        tick(1);

        // Kill beats a same-cycle request
        req_valid = 1'b1; req_mode = 3'd1; kill = 1'b1;
        expect_at(0, 3'd0, 1'b0, 1'b0, 1'b0, "t5_ready_low");
        expect_at(1, 3'd0, 1'b1, 1'b1, 1'b0, "t5_kill_wins");
        tick(1); req_valid = 1'b0; kill = 1'b0; clr = 1'b1;
        expect_at(1, 3'd0, 1'b0, 1'b0, 1'b1, "t5_cleared");
        tick(1); clr = 1'b0;
        tick(1);

        // Async reset in the middle of BAL_N on-time
        req_valid = 1'b1; req_mode = 3'd4;
        tick(1); req_valid = 1'b0;
        tick(4);
        expect_at(0, 3'd4, 1'b1, 1'b0, 1'b0, "t5_baln_on");
        #5;
        rst_cnt++;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick(1);
        expect_at(0, 3'd0, 1'b0, 1'b0, 1'b1, "t5_after_rst");
        tick(1);

        // Random requests and kills, covered by the invariant monitors
        for (int i = 0; i < 4000; i++) begin
            kill      = ($urandom_range(0, 59) == 0);
            clr       = ($urandom_range(0, 7) == 0);
            req_valid = ($urandom_range(0, 3) != 0);
            req_mode  = 3'($urandom_range(0, 7));
            tick(1);
        end
        kill = 1'b0; req_valid = 1'b0; clr = 1'b1;
        tick(1); clr = 1'b0;
        tick(20);
        done = 1'b1;
        tick(5);
        $display("FAIL monitor_timeout: monitor did not finish, expected summary");
        $fatal(1);
    end

endmodule
